// File: rtl/slt_mod.sv
// Registered signed set-less-than unit built on a ripple-carry subtractor.
// Optional macro SLT_MOD_UNSIGNED_EN adds the `uns` input selecting an unsigned compare.
module slt_mod #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SLT_MOD_UNSIGNED_EN
  input  logic            uns,
`endif
  input  logic [size-1:0] R2,
  input  logic [size-1:0] R3,
  output logic [size-1:0] R1,
  output logic            c_out
);

  localparam int MSB = size - 1;

  logic [size:0]   carry;
  logic [size-1:0] diff;
  logic            ovf;
  logic            lt;
  logic            flag;
  logic [size-1:0] r1_d, r1_q;
  logic            c_out_d, c_out_q;

  // R2 - R3 as R2 + ~R3 + 1: the +1 enters as the initial carry.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < size; gi++) begin : g_rca
      assign diff[gi]      = R2[gi] ^ ~R3[gi] ^ carry[gi];
      assign carry[gi + 1] = (R2[gi] & ~R3[gi]) | (carry[gi] & (R2[gi] ^ ~R3[gi]));
    end
  endgenerate

  always_comb begin
    ovf  = (R2[MSB] != R3[MSB]) && (diff[MSB] != R2[MSB]);
    lt   = diff[MSB] ^ ovf;
    flag = lt;
`ifdef SLT_MOD_UNSIGNED_EN
    // No borrow out of the subtractor means R2 >= R3 unsigned.
    if (uns) begin
      flag = ~carry[size];
    end
`endif
    r1_d    = '0;
    r1_d[0] = flag;
    c_out_d = carry[size];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q    <= '0;
      c_out_q <= 1'b0;
    end else begin
      r1_q    <= r1_d;
      c_out_q <= c_out_d;
    end
  end

  assign R1    = r1_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_slt_mod.sv
// Scoreboard bench for slt_mod (size = 4): expected results are queued at drive time
// and popped when the registered result appears one edge later.
module tb_slt_mod;

  typedef struct {
    string      tag;
    logic [3:0] r1;
    logic       c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       uns_s;
  logic [3:0] R2;
  logic [3:0] R3;
  logic [3:0] R1;
  logic       c_out;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  slt_mod #(.size(4)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SLT_MOD_UNSIGNED_EN
    .uns   (uns_s),
`endif
    .R2    (R2),
    .R3    (R3),
    .R1    (R1),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one compare, queue the independently modelled result, then check it after the edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic r, input logic u);
    exp_t e;
    logic lt_s;
    logic lt_u;
    lt_s = ($signed(a) < $signed(b));
    lt_u = (a < b);
    e.tag = tag;
    if (r) begin
      e.r1 = 4'b0000;
      e.c  = 1'b0;
    end else begin
      e.r1 = {3'b000, (u ? lt_u : lt_s)};
      e.c  = ~lt_u;
    end
    R2 = a; R3 = b; rst = r; uns_s = u;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_R1"}, {4'b0000, R1}, {4'b0000, e.r1});
      chk({e.tag, "_c_out"}, {7'b0, c_out}, {7'b0, e.c});
      $display("txn %s R2=%b R3=%b rst=%0b uns=%0b -> R1=%b c_out=%0b",
               e.tag, a, b, r, u, R1, c_out);
    end
  endtask

  initial begin
    logic [3:0] b;
    rst = 1'b1; R2 = 4'b0101; R3 = 4'b0011; uns_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_R1", {4'b0000, R1}, 8'd0);
    chk("reset_c_out", {7'b0, c_out}, 8'd0);

    // Directed cases, including the result from the written table.
    step("equal",    4'b1100, 4'b1100, 1'b0, 1'b0);
    chk("equal_lit_R1", {4'b0000, R1}, 8'd0);
    chk("equal_lit_c",  {7'b0, c_out}, 8'd1);
    step("neg_lt",   4'b1100, 4'b1101, 1'b0, 1'b0);
    chk("neg_lt_lit_R1", {4'b0000, R1}, 8'd1);
    chk("neg_lt_lit_c",  {7'b0, c_out}, 8'd0);
    step("overflow", 4'b1100, 4'b0111, 1'b0, 1'b0);
    chk("ovf_lit_R1", {4'b0000, R1}, 8'd1);
    chk("ovf_lit_c",  {7'b0, c_out}, 8'd1);
    step("greater",  4'b1100, 4'b1011, 1'b0, 1'b0);
    chk("gt_lit_R1", {4'b0000, R1}, 8'd0);
    chk("gt_lit_c",  {7'b0, c_out}, 8'd1);
    step("minmax",   4'b1000, 4'b0111, 1'b0, 1'b0);
    step("maxmin",   4'b0111, 4'b1000, 1'b0, 1'b0);

    // Sweep R3 through wrap-around with a reset pulse in the middle.
    b = 4'b1100;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        step("sweep_rst", 4'b1100, b, 1'b1, 1'b0);
      end
      step($sformatf("sweep%0d", i), 4'b1100, b, 1'b0, 1'b0);
      b = b + 4'd1;
    end

    // Random compares.
    for (int i = 0; i < 24; i++) begin
      step($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'b0, 1'b0);
    end

`ifdef SLT_MOD_UNSIGNED_EN
    step("uns_ge", 4'b1100, 4'b0011, 1'b0, 1'b1);
    step("uns_lt", 4'b1100, 4'b1101, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("urand%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'b0, 1'($urandom_range(0, 1)));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
